uart_bridge: RTL

UART_BRIDGE -- requirements
Module: uart_bridge

---
 rtl/uart_bridge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_bridge.sv
// uart_bridge: CPU-side byte FIFOs bridged to a memory-mapped UART by a polling FSM.
// Define UART_BRIDGE_RX_EN to build the receive path (RX FIFO, RX states, overrun flag).
module uart_bridge #(
   parameter int          DEPTH    = 16,
   parameter logic [15:0] BAUD_DIV = 16'd433,
   parameter logic [7:0]  CONF     = 8'h18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_wr_en,
   input  logic [7:0]  tx_wr_data,
   output logic        tx_full,
   input  logic        rx_rd_en,
   output logic [7:0]  rx_rd_data,
   output logic        rx_empty,
   output logic        rx_overrun,
   output logic        u_we,
   output logic [3:0]  u_addr,
   output logic [31:0] u_wdata,
   input  logic [31:0] u_rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] S_INIT_BAUD = 3'd0;
   localparam logic [2:0] S_INIT_CONF = 3'd1;
   localparam logic [2:0] S_POLL      = 3'd2;
   localparam logic [2:0] S_TX_LOAD   = 3'd3;
   localparam logic [2:0] S_TX_GO     = 3'd4;
   localparam logic [2:0] S_RX_READ   = 3'd5;
   localparam logic [2:0] S_RX_ACK    = 3'd6;

   logic [2:0]    r_state, w_next;
   logic [7:0]    r_tx_mem [DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp;
   logic [AW:0]   r_tx_cnt;
   logic          w_tx_push, w_tx_pop, w_tx_empty, w_tx_go, w_rx_go, w_unused;

   assign tx_full    = r_tx_cnt == (AW+1)'(DEPTH);
   assign w_tx_empty = r_tx_cnt == '0;
   assign w_tx_push  = tx_wr_en && !tx_full;
   assign w_tx_pop   = r_state == S_TX_LOAD && !w_tx_empty;
   assign w_tx_go    = u_rdata[31] && !u_rdata[30] && !w_tx_empty;

   always_ff @(posedge clk)
      if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_wr_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
         r_tx_cnt <= r_tx_cnt + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};
      end
   end

`ifdef UART_BRIDGE_RX_EN
   logic [7:0]    r_rx_mem [DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp;
   logic [AW:0]   r_rx_cnt;
   logic          r_overrun, w_rx_full, w_rx_push, w_rx_pop;

   assign rx_empty   = r_rx_cnt == '0;
   assign w_rx_full  = r_rx_cnt == (AW+1)'(DEPTH);
   assign w_rx_push  = r_state == S_RX_READ && !w_rx_full;
   assign w_rx_pop   = rx_rd_en && !rx_empty;
   assign rx_rd_data = rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
   assign rx_overrun = r_overrun;
   assign w_rx_go    = u_rdata[29] && !w_rx_full;
   assign w_unused   = ^u_rdata[28:8];

   always_ff @(posedge clk)
      if (w_rx_push) r_rx_mem[r_rx_wp] <= u_rdata[7:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_wp   <= '0;
         r_rx_rp   <= '0;
         r_rx_cnt  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
         r_rx_cnt <= r_rx_cnt + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};
         // the byte stays in the UART; only the sticky flag records the stall
         if (r_state == S_POLL && u_rdata[29] && w_rx_full) r_overrun <= 1'b1;
      end
   end
`else
   assign rx_empty   = 1'b1;
   assign rx_rd_data = 8'h00;
   assign rx_overrun = 1'b0;
   assign w_rx_go    = 1'b0;
   assign w_unused   = ^{rx_rd_en, u_rdata[28:0]};
`endif

   always_comb begin
      w_next = r_state == S_INIT_BAUD ? S_INIT_CONF :
               r_state == S_INIT_CONF ? S_POLL :
               r_state == S_POLL      ? (w_rx_go ? S_RX_READ : w_tx_go ? S_TX_LOAD : S_POLL) :
               r_state == S_TX_LOAD   ? S_TX_GO :
               r_state == S_RX_READ   ? S_RX_ACK : S_POLL;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_INIT_BAUD;
      else r_state <= w_next;
   end

   always_comb begin
      u_we    = !(r_state == S_POLL || r_state == S_RX_READ);
      u_addr  = r_state == S_INIT_BAUD ? 4'd4 :
                r_state == S_INIT_CONF ? 4'd6 :
                r_state == S_TX_LOAD   ? 4'd9 :
                r_state == S_RX_READ   ? 4'd8 : 4'd7;
      u_wdata = r_state == S_INIT_BAUD ? {16'b0, BAUD_DIV} :
                r_state == S_INIT_CONF ? {8'b0, CONF, 16'b0} :
                r_state == S_TX_LOAD   ? {16'b0, r_tx_mem[r_tx_rp], 8'b0} :
                r_state == S_TX_GO     ? {2'b01, u_rdata[29], 29'b0} :
                r_state == S_RX_ACK    ? {1'b0, u_rdata[30], 30'b0} : 32'b0;
   end
endmodule
